mbox_port_arb: RTL and testbench

Arbiter and sequencer for the single EBOX-side MBOX request port, shared by the EBOX microcode memory path and the channel (CCW/CCL) path. It selects one requester, latches its address and direction, drives the MBOX request handshake including cache retry and backoff, and enforces a response timeout. It returns a one-cycle ack or error pulse to the winning requester. It sits between the EBOX/channel logic and the cache/MBOX interface inside the EBOX top level.

---
 rtl/mbox_port_arb_pkg.sv | 29 ++
 rtl/mbox_arb_timer.sv | 54 +++++
 rtl/mbox_port_arb.sv | 179 +++++++++++++++++
 tb/tb_mbox_port_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbox_port_arb_pkg.sv
// rtl/mbox_port_arb_pkg.sv - shared types and defaults for the MBOX port arbiter.
package mbox_port_arb_pkg;

  // Addresses are PDP-10 bits 13:35; bit 35 (the word LSB) sits at index 0.
  localparam int ADR_W = 23;
  localparam int CNT_W = 8;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int RETRY_MAX_DEF      = 15;
  localparam int RETRY_BACKOFF_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    SRC_EBOX = 1'b0,
    SRC_CHAN = 1'b1
  } arb_src_t;

  function automatic logic arb_counting(input arb_state_t s);
    return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_BACKOFF);
  endfunction

endpackage

// File: rtl/mbox_arb_timer.sv
// rtl/mbox_arb_timer.sv - retry, backoff and timeout counters for one transfer.
module mbox_arb_timer
  import mbox_port_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int RETRY_MAX      = RETRY_MAX_DEF,
  parameter int RETRY_BACKOFF  = RETRY_BACKOFF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  arb_state_t state,
  input  logic       retry,
  output logic       backoff_done,
  output logic       retry_limit,
  output logic       timeout_hit
);

  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] backoff_cnt_q, backoff_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    retry_cnt_d   = retry_cnt_q;
    backoff_cnt_d = '0;
    timeout_cnt_d = timeout_cnt_q;
    if (clear) begin
      retry_cnt_d   = '0;
      timeout_cnt_d = '0;
    end else begin
      if (retry) retry_cnt_d = retry_cnt_q + 1'b1;
      if (state == ST_BACKOFF) backoff_cnt_d = backoff_cnt_q + 1'b1;
      if (arb_counting(state)) timeout_cnt_d = timeout_cnt_q + 1'b1;
    end
  end

  // Each flag means "the event being counted this cycle reaches the limit".
  assign backoff_done = (state == ST_BACKOFF) && (backoff_cnt_q == CNT_W'(RETRY_BACKOFF - 1));
  assign retry_limit  = (retry_cnt_q == CNT_W'(RETRY_MAX - 1));
  assign timeout_hit  = arb_counting(state) && (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt_q   <= '0;
      backoff_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      retry_cnt_q   <= retry_cnt_d;
      backoff_cnt_q <= backoff_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

endmodule

// File: rtl/mbox_port_arb.sv
// rtl/mbox_port_arb.sv - arbitrates EBOX and channel onto the single MBOX request port.
module mbox_port_arb
  import mbox_port_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int RETRY_MAX      = RETRY_MAX_DEF,
  parameter int RETRY_BACKOFF  = RETRY_BACKOFF_DEF
) (
  input  logic             eboxClk,
  input  logic             eboxReset,
  input  logic             eboxReq,
  input  logic             eboxWrite,
  input  logic [ADR_W-1:0] EBOX_VMA,
  output logic             eboxAck,
  output logic             eboxErr,
  input  logic             chanReq,
  input  logic             chanWrite,
  input  logic [ADR_W-1:0] chanAdr,
  output logic             chanAck,
  output logic             chanErr,
  output logic             mboxReq,
  output logic [ADR_W-1:0] mboxAdr,
  output logic             mboxWrite,
  output logic             mboxChan,
  input  logic             cshEBOXT0,
  input  logic             cshEBOXRetry,
  input  logic             mboxRespIn,
  output logic             arbTimeout,
  output logic             arbBusy
);

  arb_state_t       state_q, state_d;
  arb_src_t         src_q, src_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             write_q, write_d;
  logic             last_chan_q, last_chan_d;
  logic             tmo_q, tmo_d;
  logic             mbox_req_q, mbox_req_d;
  logic             busy_q, busy_d;
  logic             ebox_ack_q, ebox_ack_d, ebox_err_q, ebox_err_d;
  logic             chan_ack_q, chan_ack_d, chan_err_q, chan_err_d;

  logic grant, win_chan, go_done, go_err, go_tmo;
  logic backoff_done, retry_limit, timeout_hit, retry_evt;

  assign retry_evt = cshEBOXRetry && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));

  mbox_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RETRY_MAX     (RETRY_MAX),
    .RETRY_BACKOFF (RETRY_BACKOFF)
  ) u_timer (
    .clk         (eboxClk),
    .rst         (eboxReset),
    .clear       (grant),
    .state       (state_q),
    .retry       (retry_evt),
    .backoff_done(backoff_done),
    .retry_limit (retry_limit),
    .timeout_hit (timeout_hit)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    adr_d       = adr_q;
    write_d     = write_q;
    last_chan_d = last_chan_q;
    grant       = 1'b0;
    win_chan    = 1'b0;
    go_done     = 1'b0;
    go_err      = 1'b0;
    go_tmo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eboxReq || chanReq) begin
          grant       = 1'b1;
          win_chan    = chanReq && !(eboxReq && last_chan_q);
          src_d       = win_chan ? SRC_CHAN : SRC_EBOX;
          adr_d       = win_chan ? chanAdr : EBOX_VMA;
          write_d     = win_chan ? chanWrite : eboxWrite;
          last_chan_d = win_chan;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Retry outranks T0; a T0 with response outranks the timeout.
        if (cshEBOXRetry) begin
          if (timeout_hit) begin
            go_done = 1'b1; go_err = 1'b1; go_tmo = 1'b1;
          end else if (retry_limit) begin
            go_done = 1'b1; go_err = 1'b1;
          end else begin
            state_d = ST_BACKOFF;
          end
        end else if (cshEBOXT0 && mboxRespIn) begin
          go_done = 1'b1;
        end else if (timeout_hit) begin
          go_done = 1'b1; go_err = 1'b1; go_tmo = 1'b1;
        end else if (cshEBOXT0) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mboxRespIn) begin
          go_done = 1'b1;
        end else if (timeout_hit) begin
          go_done = 1'b1; go_err = 1'b1; go_tmo = 1'b1;
        end else if (cshEBOXRetry) begin
          if (retry_limit) begin
            go_done = 1'b1; go_err = 1'b1;
          end else begin
            state_d = ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        if (timeout_hit) begin
          go_done = 1'b1; go_err = 1'b1; go_tmo = 1'b1;
        end else if (backoff_done) begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (go_done) state_d = ST_DONE;

    tmo_d      = tmo_q | go_tmo;
    mbox_req_d = (state_d == ST_ISSUE);
    busy_d     = (state_d != ST_IDLE);
    ebox_ack_d = go_done && !go_err && (src_d == SRC_EBOX);
    ebox_err_d = go_done && go_err && (src_d == SRC_EBOX);
    chan_ack_d = go_done && !go_err && (src_d == SRC_CHAN);
    chan_err_d = go_done && go_err && (src_d == SRC_CHAN);
  end

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_EBOX;
      adr_q       <= '0;
      write_q     <= 1'b0;
      last_chan_q <= 1'b0;
      tmo_q       <= 1'b0;
      mbox_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      ebox_ack_q  <= 1'b0;
      ebox_err_q  <= 1'b0;
      chan_ack_q  <= 1'b0;
      chan_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      adr_q       <= adr_d;
      write_q     <= write_d;
      last_chan_q <= last_chan_d;
      tmo_q       <= tmo_d;
      mbox_req_q  <= mbox_req_d;
      busy_q      <= busy_d;
      ebox_ack_q  <= ebox_ack_d;
      ebox_err_q  <= ebox_err_d;
      chan_ack_q  <= chan_ack_d;
      chan_err_q  <= chan_err_d;
    end
  end

  assign mboxReq    = mbox_req_q;
  assign mboxAdr    = adr_q;
  assign mboxWrite  = write_q;
  assign mboxChan   = src_q;
  assign arbTimeout = tmo_q;
  assign arbBusy    = busy_q;
  assign eboxAck    = ebox_ack_q;
  assign eboxErr    = ebox_err_q;
  assign chanAck    = chan_ack_q;
  assign chanErr    = chan_err_q;

endmodule

// File: tb/tb_mbox_port_arb.sv
// tb/tb_mbox_port_arb.sv - directed bench for mbox_port_arb (default and short-timeout instances).
module tb_mbox_port_arb;

  logic        eboxClk = 1'b0;
  logic        eboxReset = 1'b1;
  logic        eboxReq = 1'b0, eboxWrite = 1'b0;
  logic [22:0] EBOX_VMA = '0;
  logic        chanReq = 1'b0, chanWrite = 1'b0;
  logic [22:0] chanAdr = '0;
  logic        cshEBOXT0 = 1'b0, cshEBOXRetry = 1'b0, mboxRespIn = 1'b0;

  logic        eboxAck, eboxErr, chanAck, chanErr, mboxReq, mboxWrite, mboxChan, arbTimeout, arbBusy;
  logic [22:0] mboxAdr;
  logic        eboxAck_t, eboxErr_t, chanAck_t, chanErr_t, mboxReq_t, mboxWrite_t, mboxChan_t;
  logic        arbTimeout_t, arbBusy_t;
  logic [22:0] mboxAdr_t;

  int total = 0;
  int bad = 0;

  always #5 eboxClk = ~eboxClk;

  mbox_port_arb dut (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .eboxReq(eboxReq), .eboxWrite(eboxWrite),
    .EBOX_VMA(EBOX_VMA), .eboxAck(eboxAck), .eboxErr(eboxErr), .chanReq(chanReq),
    .chanWrite(chanWrite), .chanAdr(chanAdr), .chanAck(chanAck), .chanErr(chanErr),
    .mboxReq(mboxReq), .mboxAdr(mboxAdr), .mboxWrite(mboxWrite), .mboxChan(mboxChan),
    .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
    .arbTimeout(arbTimeout), .arbBusy(arbBusy)
  );

  mbox_port_arb #(.TIMEOUT_CYCLES(8)) dut_to (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .eboxReq(eboxReq), .eboxWrite(eboxWrite),
    .EBOX_VMA(EBOX_VMA), .eboxAck(eboxAck_t), .eboxErr(eboxErr_t), .chanReq(chanReq),
    .chanWrite(chanWrite), .chanAdr(chanAdr), .chanAck(chanAck_t), .chanErr(chanErr_t),
    .mboxReq(mboxReq_t), .mboxAdr(mboxAdr_t), .mboxWrite(mboxWrite_t), .mboxChan(mboxChan_t),
    .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
    .arbTimeout(arbTimeout_t), .arbBusy(arbBusy_t)
  );

  task automatic tick;
    @(posedge eboxClk);
    #1;
  endtask

  task automatic do_reset;
    eboxReq = 0; chanReq = 0; eboxWrite = 0; chanWrite = 0;
    cshEBOXT0 = 0; cshEBOXRetry = 0; mboxRespIn = 0;
    eboxReset = 1'b1;
    tick; tick;
    eboxReset = 1'b0;
  endtask

  task automatic test_reset;
    logic [33:0] obs;
    eboxReset = 1'b1;
    tick;
    obs = {eboxAck, eboxErr, chanAck, chanErr, mboxReq, mboxWrite, mboxChan, arbTimeout, arbBusy,
           mboxAdr, arbTimeout_t, arbBusy_t};
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    do_reset;
  endtask

  task automatic test_single_read;
    do_reset;
    eboxReq = 1; EBOX_VMA = 23'o1000;
    tick; // c1 ISSUE
    total++; if ({mboxReq, mboxChan, mboxWrite} !== 3'b100) begin bad++;
      $display("FAIL single_c1_ctl got=%b want=100", {mboxReq, mboxChan, mboxWrite}); end
    total++; if (mboxAdr !== 23'o1000) begin bad++;
      $display("FAIL single_adr got=%o want=1000", mboxAdr); end
    cshEBOXT0 = 1;
    tick; cshEBOXT0 = 0; // c2 WAIT
    total++; if (mboxReq !== 1'b0) begin bad++; $display("FAIL single_c2_req got=%b want=0", mboxReq); end
    tick; mboxRespIn = 1; // c3
    total++; if ({mboxReq, eboxAck} !== 2'b00) begin bad++;
      $display("FAIL single_c3 got=%b want=00", {mboxReq, eboxAck}); end
    tick; mboxRespIn = 0; eboxReq = 0; // c4 DONE
    total++; if ({eboxAck, eboxErr, chanAck, chanErr, mboxReq} !== 5'b10000) begin bad++;
      $display("FAIL single_c4_ack got=%b want=10000", {eboxAck, eboxErr, chanAck, chanErr, mboxReq}); end
    tick; // c5 IDLE
    total++; if ({eboxAck, arbBusy} !== 2'b00) begin bad++;
      $display("FAIL single_c5_idle got=%b want=00", {eboxAck, arbBusy}); end
  endtask

  task automatic test_contention;
    logic ec;
    do_reset;
    eboxReq = 1; chanReq = 1; EBOX_VMA = 23'o1234; chanAdr = 23'o7777; chanWrite = 1; eboxWrite = 0;
    for (int i = 0; i < 4; i++) begin
      ec = (i % 2 == 0);
      tick; // ISSUE
      total++; if ({mboxReq, mboxChan, mboxWrite} !== {1'b1, ec, ec}) begin bad++;
        $display("FAIL contend_grant%0d got=%b want=%b", i, {mboxReq, mboxChan, mboxWrite}, {1'b1, ec, ec}); end
      total++; if (mboxAdr !== (ec ? 23'o7777 : 23'o1234)) begin bad++;
        $display("FAIL contend_adr%0d got=%o", i, mboxAdr); end
      cshEBOXT0 = 1; mboxRespIn = 1;
      tick; // DONE
      cshEBOXT0 = 0; mboxRespIn = 0;
      total++; if ({chanAck, chanErr, eboxAck, eboxErr} !== {ec, 1'b0, ~ec, 1'b0}) begin bad++;
        $display("FAIL contend_ack%0d got=%b want=%b", i, {chanAck, chanErr, eboxAck, eboxErr}, {ec, 1'b0, ~ec, 1'b0}); end
      if (i == 3) begin eboxReq = 0; chanReq = 0; end
      tick; // IDLE
      total++; if ({chanAck, eboxAck, arbBusy, mboxReq} !== 4'b0000) begin bad++;
        $display("FAIL contend_idle%0d got=%b want=0000", i, {chanAck, eboxAck, arbBusy, mboxReq}); end
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    eboxReq = 1; EBOX_VMA = 23'o55;
    tick; cshEBOXT0 = 1; mboxRespIn = 1; // c1 ISSUE
    tick; cshEBOXT0 = 0; mboxRespIn = 0; // c2 DONE
    total++; if (eboxAck !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b want=1", eboxAck); end
    tick; // c3 IDLE gap
    total++; if ({mboxReq, arbBusy, eboxAck} !== 3'b000) begin bad++;
      $display("FAIL b2b_gap got=%b want=000", {mboxReq, arbBusy, eboxAck}); end
    tick; cshEBOXT0 = 1; mboxRespIn = 1; // c4 ISSUE
    total++; if (mboxReq !== 1'b1) begin bad++; $display("FAIL b2b_reissue got=%b want=1", mboxReq); end
    tick; cshEBOXT0 = 0; mboxRespIn = 0; eboxReq = 0; // c5 DONE
    total++; if (eboxAck !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b want=1", eboxAck); end
    tick;
  endtask

  task automatic test_retry;
    do_reset;
    eboxReq = 1; EBOX_VMA = 23'o200;
    tick; // c1 ISSUE
    for (int r = 0; r < 2; r++) begin
      cshEBOXRetry = 1;
      tick; cshEBOXRetry = 0;
      total++; if ({mboxReq, eboxAck, eboxErr} !== 3'b000) begin bad++;
        $display("FAIL retry_bo1_%0d got=%b want=000", r, {mboxReq, eboxAck, eboxErr}); end
      tick;
      total++; if (mboxReq !== 1'b0) begin bad++; $display("FAIL retry_bo2_%0d got=%b want=0", r, mboxReq); end
      tick;
      total++; if (mboxReq !== 1'b1) begin bad++; $display("FAIL retry_reissue%0d got=%b want=1", r, mboxReq); end
    end
    cshEBOXT0 = 1; mboxRespIn = 1;
    tick; cshEBOXT0 = 0; mboxRespIn = 0; eboxReq = 0;
    total++; if ({eboxAck, eboxErr} !== 2'b10) begin bad++;
      $display("FAIL retry_ack got=%b want=10", {eboxAck, eboxErr}); end
    tick;
  endtask

  task automatic test_retry_limit;
    do_reset;
    chanReq = 1; chanAdr = 23'o4321;
    tick; // ISSUE
    for (int r = 1; r <= 15; r++) begin
      total++; if (mboxReq !== 1'b1) begin bad++; $display("FAIL rlim_issue%0d got=%b want=1", r, mboxReq); end
      cshEBOXRetry = 1;
      tick; cshEBOXRetry = 0;
      if (r == 15) begin
        chanReq = 0;
        total++; if ({chanErr, chanAck, eboxErr, eboxAck, arbTimeout} !== 5'b10000) begin bad++;
          $display("FAIL rlim_err got=%b want=10000", {chanErr, chanAck, eboxErr, eboxAck, arbTimeout}); end
      end else begin
        total++; if ({chanErr, chanAck} !== 2'b00) begin bad++;
          $display("FAIL rlim_early%0d got=%b want=00", r, {chanErr, chanAck}); end
        tick; tick;
      end
    end
    tick;
    total++; if ({chanErr, arbBusy} !== 2'b00) begin bad++;
      $display("FAIL rlim_after got=%b want=00", {chanErr, arbBusy}); end
  endtask

  task automatic test_timeout;
    do_reset;
    eboxReq = 1; EBOX_VMA = 23'o17;
    tick; // c1 ISSUE entry
    for (int k = 2; k <= 8; k++) begin
      tick;
      if (eboxErr_t !== 1'b0) begin total++; bad++; $display("FAIL tmo_early c%0d got=1 want=0", k); end
    end
    tick; eboxReq = 0; // c9
    total++; if ({eboxErr_t, eboxAck_t, arbTimeout_t} !== 3'b101) begin bad++;
      $display("FAIL tmo_err got=%b want=101", {eboxErr_t, eboxAck_t, arbTimeout_t}); end
    for (int k = 0; k < 3; k++) tick;
    total++; if ({arbTimeout_t, eboxErr_t, arbBusy_t} !== 3'b100) begin bad++;
      $display("FAIL tmo_sticky got=%b want=100", {arbTimeout_t, eboxErr_t, arbBusy_t}); end
    do_reset;
    total++; if (arbTimeout_t !== 1'b0) begin bad++; $display("FAIL tmo_cleared got=%b want=0", arbTimeout_t); end
  endtask

  task automatic test_timeout_race;
    do_reset;
    eboxReq = 1; EBOX_VMA = 23'o21;
    tick; cshEBOXT0 = 1; // c1
    tick; cshEBOXT0 = 0; // c2 WAIT
    for (int k = 3; k <= 8; k++) tick;
    mboxRespIn = 1; // c8 is the timeout cycle
    tick; mboxRespIn = 0; eboxReq = 0; // c9
    total++; if ({eboxAck_t, eboxErr_t, arbTimeout_t} !== 3'b100) begin bad++;
      $display("FAIL race_ack got=%b want=100", {eboxAck_t, eboxErr_t, arbTimeout_t}); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    logic [27:0] obs;
    do_reset;
    eboxReq = 1; eboxWrite = 1; EBOX_VMA = 23'o3777;
    tick; cshEBOXT0 = 1;
    tick; cshEBOXT0 = 0; // WAIT
    total++; if ({arbBusy, mboxWrite, mboxAdr} !== {2'b11, 23'o3777}) begin bad++;
      $display("FAIL rstw_pre got=%b %o", {arbBusy, mboxWrite}, mboxAdr); end
    #3; eboxReset = 1'b1; #1;
    obs = {eboxAck, eboxErr, mboxReq, mboxWrite, arbBusy, mboxAdr};
    total++; if (obs !== '0) begin bad++; $display("FAIL rstw_async got=%h want=0", obs); end
    eboxReq = 0; eboxWrite = 0;
    tick; eboxReset = 1'b0; mboxRespIn = 1;
    for (int k = 0; k < 4; k++) begin
      tick;
      if ({eboxAck, eboxErr, chanAck, chanErr, arbBusy} !== 5'b0) begin total++; bad++;
        $display("FAIL rstw_post%0d got=%b want=00000", k, {eboxAck, eboxErr, chanAck, chanErr, arbBusy}); end
    end
    total++; if (arbBusy !== 1'b0) begin bad++; $display("FAIL rstw_idle got=%b want=0", arbBusy); end
    mboxRespIn = 0;
  endtask

  task automatic test_adr_stable;
    do_reset;
    chanReq = 1; chanWrite = 1; chanAdr = 23'o52525;
    tick; cshEBOXT0 = 1;
    tick; cshEBOXT0 = 0; chanAdr = 23'o12345; chanWrite = 0; // WAIT
    tick; mboxRespIn = 1;
    total++; if ({mboxAdr, mboxWrite, mboxChan} !== {23'o52525, 2'b11}) begin bad++;
      $display("FAIL stable_wait got=%o %b", mboxAdr, {mboxWrite, mboxChan}); end
    tick; mboxRespIn = 0; chanReq = 0; // DONE
    total++; if ({mboxAdr, chanAck, eboxAck} !== {23'o52525, 2'b10}) begin bad++;
      $display("FAIL stable_done got=%o %b", mboxAdr, {chanAck, eboxAck}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_back_to_back;
    test_retry;
    test_retry_limit;
    test_timeout;
    test_timeout_race;
    test_reset_mid_wait;
    test_adr_stable;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
